trigger_pulse_shaper: RTL and testbench

Per-channel output conditioner between the laser/LArPix trigger generator and the coax drivers on the Althea board. Takes single-cycle trigger strobes (laser, LArPix 1, LArPix 2, spare) and turns each into a fixed-width pulse that the laser driver and LArPix trigger inputs can latch. It enforces a per-channel holdoff and keeps issued and dropped trigger counts for the LED/debug readout.

---
 rtl/trigger_pulse_shaper.sv | 133 +++++++++++++
 tb/tb_trigger_pulse_shaper.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_pulse_shaper.sv
`default_nettype none
// ============================================================================
// trigger_pulse_shaper -- per-channel trigger strobe to fixed-width pulse with
// holdoff and issued/dropped counters. Drop counters: TRIGGER_PULSE_SHAPER_DROP_COUNTER_EN
// Revision: 1.0
// ============================================================================
module trigger_pulse_shaper #(
    parameter int CHANNELS                = 4,
    parameter int OSCILLATOR_FREQUENCY_HZ = 100000000,
    parameter int PULSE_WIDTH_NS          = 1000,
    parameter int HOLDOFF_NS              = 9000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [CHANNELS-1:0]   trigger_in_i,
    input  logic [CHANNELS-1:0]   invert_i,
    output logic [CHANNELS-1:0]   pulse_out_o,
    output logic [CHANNELS-1:0]   busy_o,
    output logic [8*CHANNELS-1:0] issued_count_o,
    output logic [8*CHANNELS-1:0] dropped_count_o
);

    localparam int PULSE_WIDTH_COUNTS = OSCILLATOR_FREQUENCY_HZ / 1000000 * PULSE_WIDTH_NS / 1000;
    localparam int HOLDOFF_COUNTS     = OSCILLATOR_FREQUENCY_HZ / 1000000 * HOLDOFF_NS / 1000;
    localparam int MAX_COUNTS         = (PULSE_WIDTH_COUNTS > HOLDOFF_COUNTS) ?
                                        PULSE_WIDTH_COUNTS : HOLDOFF_COUNTS;
    localparam int TIMER_WIDTH        = $clog2(MAX_COUNTS + 1);

    localparam logic [TIMER_WIDTH-1:0] PULSE_LOAD   = TIMER_WIDTH'(PULSE_WIDTH_COUNTS - 1);
    localparam logic [TIMER_WIDTH-1:0] HOLDOFF_LOAD =
        TIMER_WIDTH'((HOLDOFF_COUNTS > 0) ? HOLDOFF_COUNTS - 1 : 0);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE    = TIMER_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        state_t                 state_q, state_d;
        logic [TIMER_WIDTH-1:0] timer_q, timer_d;
        logic [7:0]             issued_q, issued_d;
        logic                   pulse_q;
        logic                   busy_q;
        logic                   trig;

        assign trig = trigger_in_i[n] & enable_i;

        always_comb begin
            state_d  = state_q;
            timer_d  = timer_q;
            issued_d = issued_q;
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_d  = ST_PULSE;
                        timer_d  = PULSE_LOAD;
                        issued_d = issued_q + 8'd1;
                    end
                end
                ST_PULSE: begin
                    if (timer_q == '0) begin
                        // A zero holdoff returns straight to IDLE.
                        if (HOLDOFF_COUNTS == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HOLDOFF;
                            timer_d = HOLDOFF_LOAD;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
                ST_HOLDOFF: begin
                    if (timer_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        // Outputs register the next state so the pulse appears one cycle after the strobe.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q  <= ST_IDLE;
                timer_q  <= '0;
                issued_q <= 8'd0;
                pulse_q  <= invert_i[n];
                busy_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                timer_q  <= timer_d;
                issued_q <= issued_d;
                pulse_q  <= (state_d == ST_PULSE) ^ invert_i[n];
                busy_q   <= (state_d != ST_IDLE);
            end
        end

        assign pulse_out_o[n]          = pulse_q;
        assign busy_o[n]               = busy_q;
        assign issued_count_o[8*n +: 8] = issued_q;

`ifdef TRIGGER_PULSE_SHAPER_DROP_COUNTER_EN
        logic [7:0] dropped_q, dropped_d;
        logic       drop_hit;

        assign drop_hit  = trig & (state_q != ST_IDLE);
        assign dropped_d = (drop_hit && (dropped_q != 8'hFF)) ? dropped_q + 8'd1 : dropped_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                dropped_q <= 8'd0;
            end else begin
                dropped_q <= dropped_d;
            end
        end

        assign dropped_count_o[8*n +: 8] = dropped_q;
`else
        assign dropped_count_o[8*n +: 8] = 8'd0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_trigger_pulse_shaper.sv
`default_nettype none
// ============================================================================
// tb_trigger_pulse_shaper -- vector table, directed corner sequences and
// randomized traffic against a timestamp-based reference model.
// Revision: 1.0
// ============================================================================
module tb_trigger_pulse_shaper;

    // 100 MHz: 100 ns -> 10 counts, 300 ns -> 30 counts.
    localparam int PW = 10;
    localparam int HO = 30;

`ifdef TRIGGER_PULSE_SHAPER_DROP_COUNTER_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        enable_i;
    logic [3:0]  trigger_in_i;
    logic [3:0]  invert_i;
    logic [3:0]  pulse_out_o;
    logic [3:0]  busy_o;
    logic [31:0] issued_count_o;
    logic [31:0] dropped_count_o;

    trigger_pulse_shaper #(
        .CHANNELS                (4),
        .OSCILLATOR_FREQUENCY_HZ (100000000),
        .PULSE_WIDTH_NS          (100),
        .HOLDOFF_NS              (300)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable_i        (enable_i),
        .trigger_in_i    (trigger_in_i),
        .invert_i        (invert_i),
        .pulse_out_o     (pulse_out_o),
        .busy_o          (busy_o),
        .issued_count_o  (issued_count_o),
        .dropped_count_o (dropped_count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nc = 0;
    int nf = 0;
    int k  = 0;
    int acc [4];
    int iss [4];
    int drp [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nc++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
        end
    endtask

    // One clock: drive inputs, let the edge sample them, advance the model, compare.
    task automatic cyc(input logic r, input logic e, input logic [3:0] t, input logic [3:0] iv);
        logic [3:0]  ep, eb;
        logic [31:0] ei, ed;
        reset = r; enable_i = e; trigger_in_i = t; invert_i = iv;
        @(posedge clock);
        k++;
        for (int c = 0; c < 4; c++) begin
            if (r) begin
                acc[c] = -100000; iss[c] = 0; drp[c] = 0;
            end else if (e && t[c]) begin
                if (k - acc[c] > PW + HO) begin
                    acc[c] = k;
                    iss[c] = (iss[c] + 1) % 256;
                end else if (drp[c] < 255) begin
                    drp[c]++;
                end
            end
            ep[c] = ((k - acc[c]) < PW) ^ iv[c];
            eb[c] = ((k - acc[c]) < PW + HO);
            ei[8*c +: 8] = 8'(iss[c]);
            ed[8*c +: 8] = DROP_EN ? 8'(drp[c]) : 8'd0;
        end
        #1;
        chk("pulse_out", {28'd0, pulse_out_o}, {28'd0, ep});
        chk("busy", {28'd0, busy_o}, {28'd0, eb});
        chk("issued_count", issued_count_o, ei);
        chk("dropped_count", dropped_count_o, ed);
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] trg;
        logic [3:0] inv;
        logic [3:0] pul;
        logic [3:0] bsy;
        logic [7:0] iss0;
    } vec_t;

    vec_t vecs [10];
    int   pc;
    int   bc;

    initial begin
        reset = 1'b1; enable_i = 1'b0; trigger_in_i = '0; invert_i = '0;
        for (int c = 0; c < 4; c++) begin acc[c] = -100000; iss[c] = 0; drp[c] = 0; end

        vecs[0] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 8'd0};
        vecs[2] = '{1'b0, 1'b1, 4'b0001, 4'b1000, 4'b1001, 4'b0001, 8'd1};
        vecs[3] = '{1'b0, 1'b1, 4'b0000, 4'b1000, 4'b1001, 4'b0001, 8'd1};
        vecs[4] = '{1'b0, 1'b1, 4'b0001, 4'b1000, 4'b1001, 4'b0001, 8'd1};
        vecs[5] = '{1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 8'd1};
        vecs[6] = '{1'b0, 1'b1, 4'b0110, 4'b0001, 4'b0110, 4'b0111, 8'd1};
        vecs[7] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0};
        vecs[8] = '{1'b0, 1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b1111, 8'd1};
        vecs[9] = '{1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 8'd0};

        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].rst, vecs[i].en, vecs[i].trg, vecs[i].inv);
            chk("vec_pulse", {28'd0, pulse_out_o}, {28'd0, vecs[i].pul});
            chk("vec_busy", {28'd0, busy_o}, {28'd0, vecs[i].bsy});
            chk("vec_issued0", {24'd0, issued_count_o[7:0]}, {24'd0, vecs[i].iss0});
        end

        // Single pulse on channel 0: widths of pulse and busy.
        cyc(1, 1, 0, 0);
        repeat (9) cyc(0, 1, 0, 0);
        cyc(0, 1, 4'b0001, 0);
        pc = int'(pulse_out_o[0]); bc = int'(busy_o[0]);
        repeat (60) begin
            cyc(0, 1, 0, 0);
            pc += int'(pulse_out_o[0]); bc += int'(busy_o[0]);
        end
        chk("ch0_pulse_width", pc, PW);
        chk("ch0_busy_width", bc, PW + HO);
        chk("ch0_issued", {24'd0, issued_count_o[7:0]}, 32'd1);

        // Last holdoff cycle drops, first idle cycle accepts.
        cyc(1, 1, 0, 0);
        cyc(0, 1, 4'b0010, 0);
        repeat (PW + HO - 1) cyc(0, 1, 0, 0);
        cyc(0, 1, 4'b0010, 0);
        cyc(0, 1, 4'b0010, 0);
        chk("ch1_issued_boundary", {24'd0, issued_count_o[15:8]}, 32'd2);
        chk("ch1_dropped_boundary", {24'd0, dropped_count_o[15:8]}, DROP_EN ? 32'd1 : 32'd0);

        // Disabled triggers do nothing; disabling mid-pulse does not shorten it.
        cyc(1, 1, 0, 0);
        repeat (5) begin
            cyc(0, 0, 4'b1111, 0);
            cyc(0, 0, 4'b0000, 0);
        end
        chk("disabled_busy", {28'd0, busy_o}, 32'd0);
        chk("disabled_issued", issued_count_o, 32'd0);
        cyc(0, 1, 4'b0100, 0);
        pc = int'(pulse_out_o[2]);
        repeat (3) begin cyc(0, 1, 0, 0); pc += int'(pulse_out_o[2]); end
        repeat (40) begin cyc(0, 0, 4'b0100, 0); pc += int'(pulse_out_o[2]); end
        chk("ch2_pulse_width_en_low", pc, PW);

        // Inverted channel 3 idles high and goes low for one pulse width.
        cyc(1, 1, 0, 4'b1000);
        repeat (3) cyc(0, 1, 0, 4'b1000);
        chk("ch3_idle_high", {31'd0, pulse_out_o[3]}, 32'd1);
        cyc(0, 1, 4'b1000, 4'b1000);
        pc = int'(!pulse_out_o[3]);
        repeat (45) begin cyc(0, 1, 0, 4'b1000); pc += int'(!pulse_out_o[3]); end
        chk("ch3_low_width", pc, PW);
        chk("ch3_return_high", {31'd0, pulse_out_o[3]}, 32'd1);

        // Reset mid-pulse, then a trigger right after release.
        cyc(1, 1, 0, 0);
        cyc(0, 1, 4'b0001, 0);
        repeat (5) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("reset_cut_pulse", {28'd0, pulse_out_o}, 32'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 4'b0001, 0);
        chk("post_reset_issued", {24'd0, issued_count_o[7:0]}, 32'd1);
        chk("post_reset_busy", {31'd0, busy_o[0]}, 32'd1);

        // Issued count wraps after 256 accepted triggers.
        cyc(1, 1, 0, 0);
        repeat (256) begin
            cyc(0, 1, 4'b0001, 0);
            repeat (PW + HO) cyc(0, 1, 0, 0);
        end
        chk("issued_wrap", {24'd0, issued_count_o[7:0]}, 32'd0);

        // Dropped count saturates.
        cyc(1, 1, 0, 0);
        repeat (300) begin
            cyc(0, 1, 4'b0010, 0);
            cyc(0, 1, 0, 0);
        end
        chk("dropped_saturate", {24'd0, dropped_count_o[15:8]}, DROP_EN ? 32'd255 : 32'd0);

        // Randomized traffic against the model.
        cyc(1, 1, 0, 0);
        begin
            logic [3:0] iv;
            iv = 4'($urandom);
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 99) == 0) iv = 4'($urandom);
                cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
                    4'($urandom & $urandom & $urandom), iv);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end

endmodule
`default_nettype wire
